// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned Addr_width = 5,
  parameter int unsigned Data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Wr_en,
  input  logic [Data_width-1:0] Wr_data,
  input  logic                  Rd_en,
  output logic [Data_width-1:0] Rd_data,
  output logic                  Full,
  output logic                  Empty
);

  localparam int unsigned Depth = 2 ** Addr_width;
  localparam logic [Addr_width:0] PtrOne = (Addr_width + 1)'(1);

  logic [Data_width-1:0] mem_q [Depth];
  logic [Addr_width:0]   wr_ptr_q, wr_ptr_d;
  logic [Addr_width:0]   rd_ptr_q, rd_ptr_d;
  logic [Data_width-1:0] rd_data_q, rd_data_d;
  logic                  wr_accept, rd_accept;
  logic [Addr_width-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[Addr_width-1:0];
  assign rd_addr = rd_ptr_q[Addr_width-1:0];

  assign Empty = (wr_ptr_q == rd_ptr_q);
  assign Full  = (wr_addr == rd_addr) && (wr_ptr_q[Addr_width] != rd_ptr_q[Addr_width]);

  // Each side judged on current flags only; no empty-FIFO bypass.
  assign wr_accept = Wr_en & ~Full;
  assign rd_accept = Rd_en & ~Empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= Wr_data;
    end
  end

  assign Rd_data = rd_data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts data and flags each cycle.
module tb_sync_fifo;

  localparam int unsigned Depth = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Wr_en = 1'b0;
  logic [7:0] Wr_data = 8'h00;
  logic       Rd_en = 1'b0;
  logic [7:0] Rd_data;
  logic       Full;
  logic       Empty;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_rd = 8'h00;

  sync_fifo #(
    .Addr_width(5),
    .Data_width(8)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .Wr_en  (Wr_en),
    .Wr_data(Wr_data),
    .Rd_en  (Rd_en),
    .Rd_data(Rd_data),
    .Full   (Full),
    .Empty  (Empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_rd"}, 32'(Rd_data), 32'(exp_rd));
    check_val({tag, "_empty"}, 32'(Empty), 32'(exp_q.size() == 0));
    check_val({tag, "_full"}, 32'(Full), 32'(exp_q.size() == Depth));
  endtask

  // One clock: drive, let the edge happen, update the model, compare 1 ns later.
  task automatic cycle(input logic wr, input logic [7:0] wd, input logic rd, input string tag);
    bit wr_ok, rd_ok;
    Wr_en   = wr;
    Wr_data = wd;
    Rd_en   = rd;
    wr_ok   = wr && (exp_q.size() < Depth);
    rd_ok   = rd && (exp_q.size() > 0);
    @(posedge clk);
    if (rd_ok) exp_rd = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(wd);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Test 1: reset, then reads on an empty FIFO.
    #2;
    check_val("rst_empty", 32'(Empty), 32'd1);
    check_val("rst_full", 32'(Full), 32'd0);
    check_val("rst_rd", 32'(Rd_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cycle(1'b0, 8'h00, 1'b1, "t1_rd_empty");

    // Test 2: two writes, idle, two reads.
    cycle(1'b1, 8'h4D, 1'b0, "t2_wr");
    cycle(1'b1, 8'hFF, 1'b0, "t2_wr");
    cycle(1'b0, 8'h00, 1'b0, "t2_idle");
    cycle(1'b0, 8'h00, 1'b1, "t2_rd");
    check_val("t2_first", 32'(Rd_data), 32'h4D);
    cycle(1'b0, 8'h00, 1'b1, "t2_rd");
    check_val("t2_second", 32'(Rd_data), 32'hFF);
    check_val("t2_empty_after", 32'(Empty), 32'd1);

    // Test 3: fill to full across a pointer wrap, then an ignored write.
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'(8'h4D + i), 1'b0, "t3_fill");
    check_val("t3_full", 32'(Full), 32'd1);
    cycle(1'b1, 8'hAA, 1'b0, "t3_overflow");
    check_val("t3_full_held", 32'(Full), 32'd1);

    // Test 4: drain completely, then keep reading.
    cycle(1'b0, 8'h00, 1'b1, "t4_rd");
    check_val("t4_full_drop", 32'(Full), 32'd0);
    for (int i = 1; i < 34; i++) cycle(1'b0, 8'h00, 1'b1, "t4_rd");
    check_val("t4_hold", 32'(Rd_data), 32'h6C);
    check_val("t4_empty", 32'(Empty), 32'd1);

    // Simultaneous write+read on empty: only the write happens.
    cycle(1'b1, 8'h11, 1'b1, "t4_wr_rd_empty");
    check_val("t4_no_bypass", 32'(Rd_data), 32'h6C);
    cycle(1'b0, 8'h00, 1'b1, "t4_rd_back");

    // Test 5: five words stored, 40 cycles of concurrent write+read.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, "t5_prefill");
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h85 + i), 1'b1, "t5_stream");
    check_val("t5_occupancy", 32'(exp_q.size()), 32'd5);

    // Simultaneous write+read when full: only the read happens.
    for (int i = 0; i < 27; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, "t5_refill");
    cycle(1'b1, 8'hEE, 1'b1, "t5_wr_rd_full");
    for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1, "t5_drain");

    // Test 6: ten words stored, asynchronous reset away from the clock edge.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, "t6_fill");
    Wr_en = 1'b0;
    Rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_rd = 8'h00;
    check_val("t6_rst_empty", 32'(Empty), 32'd1);
    check_val("t6_rst_full", 32'(Full), 32'd0);
    check_val("t6_rst_rd", 32'(Rd_data), 32'd0);
    #1 rst = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, "t6_wr");
    cycle(1'b0, 8'h00, 1'b1, "t6_rd");
    check_val("t6_new_word", 32'(Rd_data), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
